// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0] branch_off;
    logic        unused_opcode;

    assign branch_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign unused_opcode = ^instr[31:26];

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetch, hold until decode accepts, then redirect.
// Optional redirect counter enabled by macro FETCH_REDIRECT_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master imem,
    output logic [31:0]  instr,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [5:0]   opcode,
    output logic [31:0]  pc,
    output logic [31:0]  pc_plus4,
    input  logic         branch,
    input  logic         jump,
    input  logic         zero,
    output logic [31:0]  redirect_cnt
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] next_pc;
    logic        accept;

    assign accept         = instr_valid & instr_ready;
    assign opcode         = instr[31:26];
    assign pc_plus4       = pc + 32'd4;
    assign imem.imem_req  = (state == S_FETCH);
    assign imem.imem_addr = pc;

    next_pc_calc u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .branch   (branch),
        .jump     (jump),
        .zero     (zero),
        .next_pc  (next_pc)
    );

    // instr_valid is only ever set in S_HOLD, so accept implies S_HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= PC_INIT;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (imem.imem_ready) begin
                        instr       <= imem.imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        state       <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_REDIRECT_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && (jump || (branch && zero))) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign redirect_cnt = cnt_q;
`else
    assign redirect_cnt = '0;
`endif

endmodule
